ssram_burst_reader: RTL and testbench
=====================================

SSRAM_BURST_READER -- requirements
Module: ssram_burst_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, SHALL set the SSRAM word-address width (512 words).
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the SSRAM and stream word width.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL request a burst; sampled only while busy=0.
REQ-006 startAddress  input  ADDR_WIDTH  SHALL give the first word address of the burst.
REQ-007 burstLength  input  ADDR_WIDTH+1  SHALL give the word count, 0..512.
REQ-008 busy  output  1  SHALL be high from the cycle after start acceptance until done.
REQ-009 done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 ramAddress  output  ADDR_WIDTH  SHALL drive the SSRAM read-port address.
REQ-011 ramWriteEnable  output  1  SHALL drive the SSRAM port write enable and be held at 0.
REQ-012 ramDataOut  input  DATA_WIDTH  SHALL be the registered SSRAM read data (1-cycle latency).
REQ-013 streamData  output  DATA_WIDTH  SHALL carry the current beat.
REQ-014 streamValid  output  1  SHALL mark streamData valid.
REQ-015 streamLast  output  1  SHALL mark the final beat of a burst.
REQ-016 streamReady  input  1  SHALL be consumer acceptance; a beat transfers when streamValid and streamReady are both high.

Function
REQ-017 FSM states SHALL be IDLE, READ and DRAIN.
REQ-018 IDLE: start=1 with burstLength>0 SHALL latch the address and length and go to READ.
REQ-019 IDLE: start=1 with burstLength=0 SHALL pulse done in the next cycle, emit no beats, and stay IDLE.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 READ: a read SHALL be issued in a cycle only when buffered + in-flight words, minus any beat transferring that cycle, is less than 2.
REQ-022 On each issue, ramAddress SHALL hold the issued address; the address register SHALL then increment modulo 2^ADDR_WIDTH (511 wraps to 0).
REQ-023 The remaining count SHALL decrement on each issue; READ SHALL go to DRAIN once the last word is issued.
REQ-024 Read data SHALL be captured into a 2-entry FIFO on the clock edge after the issue cycle.
REQ-025 streamData/streamValid SHALL present the FIFO head, in issue order.
REQ-026 While streamValid=1 and streamReady=0, streamData and streamLast SHALL be held stable.
REQ-027 streamLast SHALL be high only with the beat of the last issued word.
REQ-028 DRAIN: after the last-beat transfer, done SHALL pulse in the next cycle, busy SHALL fall in that same cycle, and the FSM SHALL return to IDLE.
REQ-029 Latency: start sampled at edge E0 SHALL give the first address in cycle E0+1 and streamValid=1 in cycle E0+3.
REQ-030 With streamReady held high, beats SHALL transfer every cycle; a burst of N SHALL complete its last beat in cycle E0+N+2.
REQ-031 No word SHALL be dropped or duplicated under any streamReady pattern.
REQ-032 A burst of 512 SHALL read every address exactly once, wrapping as needed.
REQ-033 When no read is issued, ramAddress SHALL hold its last value.

Reset
REQ-034 reset=1 SHALL force state IDLE and clear the FIFO and in-flight flag.
REQ-035 During and after reset: busy=0, done=0, streamValid=0, streamLast=0, streamData=0, ramAddress=0, ramWriteEnable=0.
REQ-036 Reset mid-burst SHALL abort it with no done pulse and no further beats; a start in the first cycle after reset SHALL be accepted.

Verification
REQ-037 RAM[10..13]=A0..A3; start@10, length 4, ready=1 -> beats A0..A3 in consecutive cycles E0+3..E0+6, last on A3, done at E0+7.
REQ-038 start@510, length 4 -> addresses 510,511,0,1 issued; data in that order.
REQ-039 Length 4 with ready toggling 1,0,0,1,0,1... -> data stable while stalled, exactly 4 beats, no loss or duplication.
REQ-040 Length 0 -> done one cycle after start, busy stays 0, no streamValid.
REQ-041 Reset asserted after the 2nd beat of an 8-word burst -> all outputs at reset values next cycle, no done; a new start@0 length 1 completes normally.
REQ-042 start pulsed while busy -> ignored; the current burst's output is unchanged.

Source files
------------

// File: rtl/ssram_burst_reader.sv
// Burst reader: fetches a run of consecutive words from a 1-cycle-latency SSRAM
// and streams them out through a 2-entry FIFO under valid/ready flow control.
module ssram_burst_reader #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] startAddress,
    input  logic [ADDR_WIDTH:0]   burstLength,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ramAddress,
    output logic                  ramWriteEnable,
    input  logic [DATA_WIDTH-1:0] ramDataOut,
    output logic [DATA_WIDTH-1:0] streamData,
    output logic                  streamValid,
    output logic                  streamLast,
    input  logic                  streamReady
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_W-1:0]        remaining_q;
    logic                    inflight_q;
    logic                    inflight_last_q;
    logic                    busy_q;
    logic                    done_q;

    logic [DATA_WIDTH-1:0]   fifo_data_q [2];
    logic [DATA_WIDTH-1:0]   fifo_data_d [2];
    logic [1:0]              fifo_vld_q;
    logic [1:0]              fifo_vld_d;
    logic [1:0]              fifo_last_q;
    logic [1:0]              fifo_last_d;

    logic                    xfer_c;
    logic [1:0]              level_c;
    logic                    issue_c;
    logic                    last_issue_c;

    assign ramAddress     = addr_q;
    assign ramWriteEnable = 1'b0;
    assign busy           = busy_q;
    assign done           = done_q;
    assign streamData     = fifo_data_q[0];
    assign streamValid    = fifo_vld_q[0];
    assign streamLast     = fifo_last_q[0];

    // Issue only while buffered + in-flight words, net of this cycle's pop, stay below 2.
    always_comb begin
        xfer_c       = fifo_vld_q[0] & streamReady;
        level_c      = 2'(fifo_vld_q[0]) + 2'(fifo_vld_q[1]) + 2'(inflight_q) - 2'(xfer_c);
        issue_c      = (state_q == READ) && (remaining_q != '0) && (level_c < 2'd2);
        last_issue_c = issue_c && (remaining_q == LEN_W'(1));
    end

    // Shift-style FIFO: pop moves slot 1 to the head, read data lands in the first free slot.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_vld_d  = fifo_vld_q;
        fifo_last_d = fifo_last_q;
        if (xfer_c) begin
            fifo_data_d[0] = fifo_data_q[1];
            fifo_vld_d[0]  = fifo_vld_q[1];
            fifo_last_d[0] = fifo_last_q[1];
            fifo_vld_d[1]  = 1'b0;
            fifo_last_d[1] = 1'b0;
        end
        if (inflight_q) begin
            if (!fifo_vld_d[0]) begin
                fifo_data_d[0] = ramDataOut;
                fifo_vld_d[0]  = 1'b1;
                fifo_last_d[0] = inflight_last_q;
            end else begin
                fifo_data_d[1] = ramDataOut;
                fifo_vld_d[1]  = 1'b1;
                fifo_last_d[1] = inflight_last_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_vld_q      <= '0;
            fifo_last_q     <= '0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue_c;
            inflight_last_q <= last_issue_c;
            fifo_data_q     <= fifo_data_d;
            fifo_vld_q      <= fifo_vld_d;
            fifo_last_q     <= fifo_last_d;

            if (issue_c) begin
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                remaining_q <= remaining_q - LEN_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (burstLength != '0) begin
                            addr_q      <= startAddress;
                            remaining_q <= burstLength;
                            busy_q      <= 1'b1;
                            state_q     <= READ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (last_issue_c) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (xfer_c && fifo_last_q[0]) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssram_burst_reader.sv
// Directed bench for ssram_burst_reader with a behavioural 512-word SSRAM.
module tb_ssram_burst_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  startAddress;
    logic [9:0]  burstLength;
    logic        busy;
    logic        done;
    logic [8:0]  ramAddress;
    logic        ramWriteEnable;
    logic [31:0] ramDataOut;
    logic [31:0] streamData;
    logic        streamValid;
    logic        streamLast;
    logic        streamReady;

    logic [31:0] mem [512];
    logic [5:0]  ready_pat = 6'b101001;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    always @(posedge clock) ramDataOut <= mem[ramAddress];

    ssram_burst_reader #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .startAddress   (startAddress),
        .burstLength    (burstLength),
        .busy           (busy),
        .done           (done),
        .ramAddress     (ramAddress),
        .ramWriteEnable (ramWriteEnable),
        .ramDataOut     (ramDataOut),
        .streamData     (streamData),
        .streamValid    (streamValid),
        .streamLast     (streamLast),
        .streamReady    (streamReady)
    );

    function automatic logic [31:0] exp_word(input int a);
        int w;
        w = a % 512;
        if (w >= 10 && w <= 13) return 32'hA0 + 32'(w - 10);
        return 32'hC0DE_0000 | 32'(w);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_valid"}, 64'(streamValid), 64'd0);
        check({tag, "_last"},  64'(streamLast), 64'd0);
        check({tag, "_data"},  64'(streamData), 64'd0);
        check({tag, "_addr"},  64'(ramAddress), 64'd0);
        check({tag, "_we"},    64'(ramWriteEnable), 64'd0);
    endtask

    // One burst: tracks every beat against the memory model, stall stability and done timing.
    task automatic run_burst(input int addr, input int len, input bit stall, input bit poke);
        int          cyc;
        int          beats;
        int          first_cyc;
        int          done_cyc;
        bit          stalled;
        logic [31:0] held;
        logic        held_last;
        startAddress = 9'(addr);
        burstLength  = 10'(len);
        streamReady  = 1'b1;
        start        = 1'b1;
        step();
        start     = 1'b0;
        cyc       = 1;
        beats     = 0;
        first_cyc = 0;
        done_cyc  = 0;
        stalled   = 1'b0;
        held      = '0;
        held_last = 1'b0;
        check("first_addr", 64'(ramAddress), 64'(addr % 512));
        while (done_cyc == 0 && cyc < 3000) begin
            if (poke && cyc == 1) begin
                start        = 1'b1;
                startAddress = 9'd200;
                burstLength  = 10'd3;
            end else begin
                start = 1'b0;
            end
            streamReady = stall ? ready_pat[cyc % 6] : 1'b1;
            if (stalled) begin
                check("stall_hold", 64'({streamValid, streamLast, streamData}),
                      64'({1'b1, held_last, held}));
                stalled = 1'b0;
            end
            if (streamValid && streamReady) begin
                check("beat_data", 64'(streamData), 64'(exp_word(addr + beats)));
                check("beat_last", 64'(streamLast), 64'(beats == len - 1));
                if (first_cyc == 0) first_cyc = cyc;
                beats++;
            end else if (streamValid) begin
                stalled   = 1'b1;
                held      = streamData;
                held_last = streamLast;
            end
            if (done) begin
                done_cyc = cyc;
                check("busy_at_done", 64'(busy), 64'd0);
            end
            check("write_enable", 64'(ramWriteEnable), 64'd0);
            step();
            cyc++;
        end
        start       = 1'b0;
        streamReady = 1'b1;
        check("done_seen", 64'(done_cyc != 0), 64'd1);
        check("beat_count", 64'(beats), 64'(len));
        if (!stall) begin
            check("first_beat_cyc", 64'(first_cyc), 64'd3);
            check("done_cyc", 64'(done_cyc), 64'(len + 3));
        end
        check("done_single", 64'(done), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = exp_word(i);
        reset        = 1'b1;
        start        = 1'b0;
        startAddress = '0;
        burstLength  = '0;
        streamReady  = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;

        // A0..A3 from address 10 with continuous ready
        run_burst(10, 4, 1'b0, 1'b0);
        // wrap 510,511,0,1
        run_burst(510, 4, 1'b0, 1'b0);
        // stalled consumer
        run_burst(40, 4, 1'b1, 1'b0);
        // start pulsed while busy
        run_burst(100, 4, 1'b0, 1'b1);
        check("idle_after_poke", 64'(busy), 64'd0);

        // zero-length burst
        startAddress = 9'd50;
        burstLength  = 10'd0;
        start        = 1'b1;
        step();
        start = 1'b0;
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_valid", 64'(streamValid), 64'd0);
        step();
        check("zero_done_clr", 64'(done), 64'd0);
        check("zero_busy2", 64'(busy), 64'd0);
        check("zero_valid2", 64'(streamValid), 64'd0);

        // reset mid-burst after the second beat
        startAddress = 9'd20;
        burstLength  = 10'd8;
        start        = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("abort_beat0", 64'({streamValid, streamData}), 64'({1'b1, exp_word(20)}));
        step();
        check("abort_beat1", 64'({streamValid, streamData}), 64'({1'b1, exp_word(21)}));
        step();
        reset = 1'b1;
        step();
        check_reset_outputs("abort");
        reset = 1'b0;
        run_burst(0, 1, 1'b0, 1'b0);

        // full 512-word burst with stalls, wrapping through address 0
        run_burst(300, 512, 1'b1, 1'b0);
        // short burst at full rate
        run_burst(7, 2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
